// File: rtl/inv_bfly_pkg.sv
// Shared definitions for the inverse radix-2 butterfly.
//   - twiddle specialisation encodings for the top-level "mult" parameter
//   - control state encoding used by the general (iterative) path
package inv_bfly_pkg;

  localparam int MULT_GENERAL = 0;  // full complex multiply by conj(w)
  localparam int MULT_ONE     = 1;  // w = 1
  localparam int MULT_NEG_ONE = 2;  // w = -1
  localparam int MULT_J       = 3;  // w = j
  localparam int MULT_NEG_J   = 4;  // w = -j

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_iterative_real_mul.sv
// Iterative signed fixed-point multiplier, one multiplier bit per cycle.
// Result p is bits [n+d-1:d] of the full 2n-bit signed product of a and b
// (truncation, wrap on overflow).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load a and b and begin (operands sampled on this cycle only)
//   a, b       : signed n-bit operands
//   done       : one-cycle pulse n cycles after start; p is valid from then on
//   p          : truncated n-bit product (held until the next completion)
module fixed_point_iterative_real_mul #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         done,
  output logic [n-1:0] p
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] BIT_LAST = CW'(n - 1);

  logic [2*n-1:0] mcand_reg;   // sign-extended a, shifted left each step
  logic [2*n-1:0] acc_reg;
  logic [2*n-1:0] addend;
  logic [2*n-1:0] acc_next;
  logic [n-1:0]   mplier_reg;  // b, shifted right each step
  logic [CW-1:0]  bit_reg;
  logic           busy_reg;

  // The multiplier MSB carries weight -2^(n-1) in two's complement, so its
  // partial product is subtracted instead of added.
  always_comb begin
    addend   = mplier_reg[0] ? mcand_reg : '0;
    acc_next = (bit_reg == BIT_LAST) ? (acc_reg - addend) : (acc_reg + addend);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      bit_reg    <= '0;
      busy_reg   <= 1'b0;
      done       <= 1'b0;
      p          <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand_reg  <= {{n{a[n-1]}}, a};
        mplier_reg <= b;
        acc_reg    <= '0;
        bit_reg    <= '0;
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        bit_reg    <= bit_reg + CW'(1);
        if (bit_reg == BIT_LAST) begin
          busy_reg <= 1'b0;
          done     <= 1'b1;
          p        <= acc_next[n+d-1:d];
        end
      end
    end
  end

endmodule

// File: rtl/fixed_point_iterative_inverse_butterfly.sv
// Radix-2 inverse (DIF) butterfly: recovers a = (c+d)/2, b = ((c-d)/2)*conj(w)
// from a butterfly output pair, with val/rdy handshakes on both sides.
// Macro INV_BUTTERFLY_HALVE_EN: when defined, sum and difference are halved
// (arithmetic shift, rounds toward -inf); when undefined they are used as-is
// and wrap to n bits. Latency does not depend on it.
// Parameters: n (word width), d (fraction bits), mult (twiddle specialisation,
// see inv_bfly_pkg; 0 = general iterative complex multiply).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   recv_val / recv_rdy : input handshake for cr, cc, dr, dc, wr, wc
//   send_val / send_rdy : output handshake for ar, ac, br, bc
module fixed_point_iterative_inverse_butterfly
  import inv_bfly_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int mult = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  output logic         send_val,
  input  logic         send_rdy,
  input  logic [n-1:0] cr,
  input  logic [n-1:0] cc,
  input  logic [n-1:0] dr,
  input  logic [n-1:0] dc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic [n-1:0] ar,
  output logic [n-1:0] ac,
  output logic [n-1:0] br,
  output logic [n-1:0] bc
);

  // Sum or difference in n+1 bits, optionally halved, kept to n bits.
  function automatic logic [n-1:0] sum_diff(input logic [n-1:0] x,
                                            input logic [n-1:0] y,
                                            input logic         sub);
`ifdef INV_BUTTERFLY_HALVE_EN
    logic [n:0] f;
    f = sub ? ({x[n-1], x} - {y[n-1], y}) : ({x[n-1], x} + {y[n-1], y});
    f = f >> 1;
    return f[n-1:0];
`else
    return sub ? (x - y) : (x + y);
`endif
  endfunction

  logic [n-1:0] sr, sc, tr, tc;
  logic         accept;

  assign sr     = sum_diff(cr, dr, 1'b0);
  assign sc     = sum_diff(cc, dc, 1'b0);
  assign tr     = sum_diff(cr, dr, 1'b1);
  assign tc     = sum_diff(cc, dc, 1'b1);
  assign accept = recv_val & recv_rdy;

  if (mult == MULT_GENERAL) begin : g_general
    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [n-1:0]  sr_reg, sc_reg;
    logic [n-1:0]  mul_a [4];
    logic [n-1:0]  mul_b [4];
    logic [n-1:0]  mul_p [4];
    logic [3:0]    mul_done;
    logic          products_ready;

    // Products: 0 = tr*wr, 1 = tc*wc, 2 = tc*wr, 3 = tr*wc.
    // Operands are taken straight from the accept cycle; each multiplier
    // latches its own copy, so later input changes cannot leak in.
    assign mul_a[0] = tr;  assign mul_b[0] = wr;
    assign mul_a[1] = tc;  assign mul_b[1] = wc;
    assign mul_a[2] = tc;  assign mul_b[2] = wr;
    assign mul_a[3] = tr;  assign mul_b[3] = wc;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
      fixed_point_iterative_real_mul #(.n(n), .d(d)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .a     (mul_a[gi]),
        .b     (mul_b[gi]),
        .done  (mul_done[gi]),
        .p     (mul_p[gi])
      );
    end

    assign products_ready = &mul_done;

    always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE:    if (accept)         state_next = CALC;
        CALC:    if (products_ready) state_next = DONE;
        DONE:    if (send_rdy)       state_next = IDLE;
        default:                     state_next = IDLE;
      endcase
    end

    // Handshake flags decode registered state only.
    always_comb begin
      recv_rdy = 1'b0;
      send_val = 1'b0;
      case (state_reg)
        IDLE:    recv_rdy = 1'b1;
        DONE:    send_val = 1'b1;
        default: ;
      endcase
    end

    // The counter tracks multiplier bit progress and parks at n-1 for the
    // extra cycle the multipliers need to present their registered result.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
        sr_reg  <= '0;
        sc_reg  <= '0;
        ar      <= '0;
        ac      <= '0;
        br      <= '0;
        bc      <= '0;
      end else begin
        if (accept) begin
          cnt_reg <= '0;
          sr_reg  <= sr;
          sc_reg  <= sc;
        end else if (state_reg == CALC && cnt_reg != CNT_LAST) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
        if (state_reg == CALC && products_ready) begin
          ar <= sr_reg;
          ac <= sc_reg;
          br <= mul_p[0] + mul_p[1];
          bc <= mul_p[2] - mul_p[3];
        end
      end
    end
  end else begin : g_special
    logic unused_twiddle;
    assign unused_twiddle = ^{wr, wc};

    assign recv_rdy = ~send_val;

    always_ff @(posedge clk) begin
      if (reset) begin
        send_val <= 1'b0;
        ar       <= '0;
        ac       <= '0;
        br       <= '0;
        bc       <= '0;
      end else if (send_val) begin
        if (send_rdy) send_val <= 1'b0;
      end else if (accept) begin
        send_val <= 1'b1;
        ar       <= sr;
        ac       <= sc;
        case (mult)
          MULT_NEG_ONE: begin br <= -tr; bc <= -tc; end
          MULT_J:       begin br <= tc;  bc <= -tr; end
          MULT_NEG_J:   begin br <= -tc; bc <= tr;  end
          default:      begin br <= tr;  bc <= tc;  end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_iterative_inverse_butterfly.sv
// Self-checking bench for fixed_point_iterative_inverse_butterfly.
// Instance dut uses the general iterative path (mult = 0), instance dut_j the
// w = j specialisation (mult = 3). Expected values come from a plain-arithmetic
// model of the butterfly equations.
module tb_fixed_point_iterative_inverse_butterfly;

  localparam int N = 32;
  localparam int D = 16;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [31:0] cr, cc, dr, dc, wr, wc, ar, ac, br, bc;

  logic        j_recv_val, j_recv_rdy, j_send_val, j_send_rdy;
  logic [31:0] j_cr, j_cc, j_dr, j_dc, j_wr, j_wc, j_ar, j_ac, j_br, j_bc;

  int n_cmp = 0;
  int n_err = 0;

  fixed_point_iterative_inverse_butterfly #(.n(N), .d(D), .mult(0)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_val(send_val), .send_rdy(send_rdy),
    .cr(cr), .cc(cc), .dr(dr), .dc(dc), .wr(wr), .wc(wc),
    .ar(ar), .ac(ac), .br(br), .bc(bc)
  );

  fixed_point_iterative_inverse_butterfly #(.n(N), .d(D), .mult(3)) dut_j (
    .clk(clk), .reset(reset),
    .recv_val(j_recv_val), .recv_rdy(j_recv_rdy),
    .send_val(j_send_val), .send_rdy(j_send_rdy),
    .cr(j_cr), .cc(j_cc), .dr(j_dr), .dc(j_dc), .wr(j_wr), .wc(j_wc),
    .ar(j_ar), .ac(j_ac), .br(j_br), .bc(j_bc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_scale(input logic [31:0] x, input logic [31:0] y, input bit sub);
    longint v;
    v = sub ? (longint'($signed(x)) - longint'($signed(y)))
            : (longint'($signed(x)) + longint'($signed(y)));
`ifdef INV_BUTTERFLY_HALVE_EN
    v = v >>> 1;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_fmul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> D;
    return p[31:0];
  endfunction

  // mode 0: b = t*conj(w); mode 3: b = t*(-j) = (tc, -tr)
  task automatic model(input int mode,
                       input logic [31:0] icr, icc, idr, idc, iwr, iwc,
                       output logic [31:0] ear, eac, ebr, ebc);
    logic [31:0] tr, tc;
    ear = m_scale(icr, idr, 1'b0);
    eac = m_scale(icc, idc, 1'b0);
    tr  = m_scale(icr, idr, 1'b1);
    tc  = m_scale(icc, idc, 1'b1);
    if (mode == 0) begin
      ebr = m_fmul(tr, iwr) + m_fmul(tc, iwc);
      ebc = m_fmul(tc, iwr) - m_fmul(tr, iwc);
    end else begin
      ebr = tc;
      ebc = -tr;
    end
  endtask

  // ---------------- transaction drivers ----------------
  task automatic run_gen(input string tag,
                         input logic [31:0] icr, icc, idr, idc, iwr, iwc,
                         input logic [31:0] ear, eac, ebr, ebc,
                         input int bp);
    int m;
    @(posedge clk); #1;
    cr = icr; cc = icc; dr = idr; dc = idc; wr = iwr; wc = iwc;
    recv_val = 1'b1;
    send_rdy = 1'b0;
    check({tag, ".recv_rdy_idle"}, 32'(recv_rdy), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept: only the accept-cycle values may matter.
    recv_val = 1'b0;
    cr = $urandom; cc = $urandom; dr = $urandom; dc = $urandom; wr = $urandom; wc = $urandom;
    check({tag, ".recv_rdy_busy"}, 32'(recv_rdy), 32'd0);
    m = 0;
    while (send_val !== 1'b1 && m < 100) begin
      @(posedge clk); #1;
      m++;
    end
    $display("%s: latency=%0d a=(%08h,%08h) b=(%08h,%08h)", tag, m, ar, ac, br, bc);
    check({tag, ".latency"}, 32'(m), 32'(LAT));
    check({tag, ".ar"}, ar, ear);
    check({tag, ".ac"}, ac, eac);
    check({tag, ".br"}, br, ebr);
    check({tag, ".bc"}, bc, ebc);
    // Backpressure: keep offering new inputs, none may be taken.
    for (int i = 0; i < bp; i++) begin
      recv_val = 1'b1;
      cr = $urandom; dr = $urandom; wr = $urandom;
      @(posedge clk); #1;
      check({tag, ".bp_send_val"}, 32'(send_val), 32'd1);
      check({tag, ".bp_recv_rdy"}, 32'(recv_rdy), 32'd0);
      check({tag, ".bp_br"}, br, ebr);
      check({tag, ".bp_ac"}, ac, eac);
    end
    send_rdy = 1'b1;
    @(posedge clk); #1;
    send_rdy = 1'b0;
    recv_val = 1'b0;
    check({tag, ".post_send_val"}, 32'(send_val), 32'd0);
    check({tag, ".post_recv_rdy"}, 32'(recv_rdy), 32'd1);
    check({tag, ".post_bc_held"}, bc, ebc);
  endtask

  task automatic run_j(input string tag,
                       input logic [31:0] icr, icc, idr, idc,
                       input logic [31:0] ear, eac, ebr, ebc);
    @(posedge clk); #1;
    j_cr = icr; j_cc = icc; j_dr = idr; j_dc = idc;
    j_wr = $urandom; j_wc = $urandom;
    j_recv_val = 1'b1;
    check({tag, ".recv_rdy"}, 32'(j_recv_rdy), 32'd1);
    @(posedge clk); #1;
    j_recv_val = 1'b0;
    j_cr = $urandom; j_dr = $urandom;
    $display("%s: send_val=%0d a=(%08h,%08h) b=(%08h,%08h)", tag, j_send_val, j_ar, j_ac, j_br, j_bc);
    check({tag, ".send_val"}, 32'(j_send_val), 32'd1);
    check({tag, ".recv_rdy_full"}, 32'(j_recv_rdy), 32'd0);
    check({tag, ".ar"}, j_ar, ear);
    check({tag, ".ac"}, j_ac, eac);
    check({tag, ".br"}, j_br, ebr);
    check({tag, ".bc"}, j_bc, ebc);
    j_send_rdy = 1'b1;
    @(posedge clk); #1;
    j_send_rdy = 1'b0;
    check({tag, ".post_send_val"}, 32'(j_send_val), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] rcr, rcc, rdr, rdc, rwr, rwc;
    logic [31:0] ear, eac, ebr, ebc;
    int m;

    reset = 1'b1;
    recv_val = 1'b0; send_rdy = 1'b0;
    cr = '0; cc = '0; dr = '0; dc = '0; wr = '0; wc = '0;
    j_recv_val = 1'b0; j_send_rdy = 1'b0;
    j_cr = '0; j_cc = '0; j_dr = '0; j_dc = '0; j_wr = '0; j_wc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.send_val", 32'(send_val), 32'd0);
    check("reset.ar", ar, 32'd0);
    check("reset.bc", bc, 32'd0);
    check("reset.j_send_val", 32'(j_send_val), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset.recv_rdy", 32'(recv_rdy), 32'd1);
    check("reset.j_recv_rdy", 32'(j_recv_rdy), 32'd1);

    // Directed vectors (1.0 = 0x00010000)
`ifdef INV_BUTTERFLY_HALVE_EN
    run_gen("identity", 32'h00020000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0,
            32'h00018000, 32'h0, 32'h00008000, 32'h00010000, 0);
    run_gen("j_twiddle", 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'h00010000,
            32'h0, 32'h0, 32'h0, 32'hFFFF0000, 0);
    run_gen("rounding", 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'h00010000, 32'h0,
            32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 5);
    run_j("spec_j", 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0,
          32'h0, 32'h0, 32'h0, 32'hFFFF0000);
`else
    run_gen("identity", 32'h00020000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0,
            32'h00030000, 32'h0, 32'h00010000, 32'h00020000, 0);
    run_gen("j_twiddle", 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'h00010000,
            32'h0, 32'h0, 32'h0, 32'hFFFE0000, 0);
    run_gen("rounding", 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'h00010000, 32'h0,
            32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5);
    run_j("spec_j", 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0,
          32'h0, 32'h0, 32'h0, 32'hFFFE0000);
`endif

    // Reset ten cycles into a calculation; the previous result is nonzero,
    // so the zeroed outputs are meaningful.
    @(posedge clk); #1;
    cr = 32'h00020000; cc = 32'h00010000; dr = 32'h00010000; dc = 32'hFFFF0000;
    wr = 32'h00010000; wc = 32'h0;
    recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    $display("mid_reset: send_val=%0d recv_rdy=%0d a=(%08h,%08h) b=(%08h,%08h)",
             send_val, recv_rdy, ar, ac, br, bc);
    check("mid_reset.send_val", 32'(send_val), 32'd0);
    check("mid_reset.recv_rdy", 32'(recv_rdy), 32'd1);
    check("mid_reset.ar", ar, 32'd0);
    check("mid_reset.br", br, 32'd0);
    reset = 1'b0;
    // No stale completion may surface after the abandoned transaction.
    m = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (send_val === 1'b1) m++;
    end
    check("mid_reset.no_stale", 32'(m), 32'd0);
    model(0, 32'h00020000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0,
          ear, eac, ebr, ebc);
    run_gen("after_reset", 32'h00020000, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h0,
            ear, eac, ebr, ebc, 1);

    // Randomized general-path transactions
    for (int k = 0; k < 16; k++) begin
      rcr = $urandom; rcc = $urandom; rdr = $urandom; rdc = $urandom;
      rwr = $urandom; rwc = $urandom;
      if (k < 4) begin
        rwr = 32'($signed(rwr) >>> 14);
        rwc = 32'($signed(rwc) >>> 14);
      end
      model(0, rcr, rcc, rdr, rdc, rwr, rwc, ear, eac, ebr, ebc);
      run_gen($sformatf("rand%0d", k), rcr, rcc, rdr, rdc, rwr, rwc,
              ear, eac, ebr, ebc, int'($urandom_range(0, 3)));
    end

    // Randomized w = j transactions
    for (int k = 0; k < 8; k++) begin
      rcr = $urandom; rcc = $urandom; rdr = $urandom; rdc = $urandom;
      model(3, rcr, rcc, rdr, rdc, 32'h0, 32'h0, ear, eac, ebr, ebc);
      run_j($sformatf("rand_j%0d", k), rcr, rcc, rdr, rdc, ear, eac, ebr, ebc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
